// File: rtl/palette_lookup_arbiter.sv
// Shared sprite palette store with round-robin colour lookup arbitration.
// Lookups and runtime palette writes share one slot per cycle; writes are
// preferred but limited to short bursts while lookups are waiting. Each
// granted lookup returns its RGB colour and transparency flag two edges later.
module palette_lookup_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_PAL      = 4,
    parameter int PAL_W        = 2,
    parameter int WR_BURST_MAX = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*PAL_W-1:0]     i_req_pal,
    input  logic [NUM_REQ*4-1:0]         i_req_idx,
    output logic [NUM_REQ-1:0]           o_gnt,
    input  logic                         i_wr_en,
    input  logic [PAL_W-1:0]             i_wr_pal,
    input  logic [3:0]                   i_wr_idx,
    input  logic [23:0]                  i_wr_color,
    output logic                         o_wr_ready,
    output logic                         o_rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   o_rsp_id,
    output logic [23:0]                  o_rsp_color,
    output logic                         o_rsp_transparent
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int AW      = PAL_W + 4;
    localparam int ENTRIES = NUM_PAL * 16;
    localparam int CNT_W   = $clog2(WR_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(WR_BURST_MAX);

    // Burst counter increment that sticks at the burst limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= BURST_LIM) ? BURST_LIM : v + 1'b1;
    endfunction

    logic                 any_req_p0;
    logic                 wr_slot_p0;
    logic                 gnt_any_p0;
    logic                 lookup_go_p0;
    logic [ID_W-1:0]      gnt_id_p0;
    logic [PAL_W-1:0]     pal_p0;
    logic [3:0]           idx_p0;
    logic [AW-1:0]        wr_addr_p0;

    logic [ID_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]     burst_cnt;

    logic                 vld_p1;
    logic [ID_W-1:0]      id_p1;
    logic [PAL_W-1:0]     pal_p1;
    logic [3:0]           idx_p1;

    logic [23:0]          pal_mem [ENTRIES];

    // ---- stage 0: slot choice and round-robin grant ----
    // Pick write vs lookup slot, then search requesters starting after the pointer.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand         = '0;
        any_req_p0   = |i_req;
        wr_slot_p0   = i_wr_en && (!any_req_p0 || (burst_cnt < BURST_LIM));
        gnt_any_p0   = 1'b0;
        gnt_id_p0    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!gnt_any_p0 && i_req[cand]) begin
                gnt_any_p0 = 1'b1;
                gnt_id_p0  = cand;
            end
        end
        lookup_go_p0 = gnt_any_p0 && !wr_slot_p0;
        o_gnt        = lookup_go_p0 ? (NUM_REQ'(1) << gnt_id_p0) : '0;
        o_wr_ready   = wr_slot_p0;
        pal_p0       = i_req_pal[int'(gnt_id_p0)*PAL_W +: PAL_W];
        idx_p0       = i_req_idx[int'(gnt_id_p0)*4 +: 4];
        wr_addr_p0   = {i_wr_pal, i_wr_idx};
    end

    // Round-robin pointer follows the last granted requester; burst counter limits write runs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            if (lookup_go_p0)
                rr_ptr <= gnt_id_p0;
            if (wr_slot_p0 && any_req_p0)
                burst_cnt <= sat_inc(burst_cnt);
            else if (lookup_go_p0 || !any_req_p0)
                burst_cnt <= '0;
        end
    end

    // Palette storage; a committed write lands on the same edge the slot is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int e = 0; e < ENTRIES; e++)
                pal_mem[e] <= '0;
        end else if (wr_slot_p0) begin
            pal_mem[wr_addr_p0] <= i_wr_color;
        end
    end

    // ---- stage 1: capture granted lookup ----
    // Valid bit is reset so in-flight lookups vanish on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= lookup_go_p0;
    end

    // Lookup payload only needs to be meaningful while vld_p1 is set.
    always_ff @(posedge i_clk) begin
        if (lookup_go_p0) begin
            id_p1  <= gnt_id_p0;
            pal_p1 <= pal_p0;
            idx_p1 <= idx_p0;
        end
    end

    // ---- stage 2: palette read and response register ----
    // Reads the pre-write contents so a same-edge write is not forwarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid       <= 1'b0;
            o_rsp_id          <= '0;
            o_rsp_color       <= '0;
            o_rsp_transparent <= 1'b0;
        end else begin
            o_rsp_valid <= vld_p1;
            if (vld_p1) begin
                o_rsp_id          <= id_p1;
                o_rsp_transparent <= (idx_p1 == 4'd0);
                o_rsp_color       <= (idx_p1 == 4'd0) ? 24'h000000 : pal_mem[{pal_p1, idx_p1}];
            end
        end
    end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Self-checking bench for palette_lookup_arbiter: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_palette_lookup_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int NUM_PAL      = 4;
    localparam int PAL_W        = 2;
    localparam int WR_BURST_MAX = 4;

    logic                       i_clk = 1'b0;
    logic                       i_rst_n;
    logic [NUM_REQ-1:0]         i_req;
    logic [NUM_REQ*PAL_W-1:0]   i_req_pal;
    logic [NUM_REQ*4-1:0]       i_req_idx;
    logic [NUM_REQ-1:0]         o_gnt;
    logic                       i_wr_en;
    logic [PAL_W-1:0]           i_wr_pal;
    logic [3:0]                 i_wr_idx;
    logic [23:0]                i_wr_color;
    logic                       o_wr_ready;
    logic                       o_rsp_valid;
    logic [1:0]                 o_rsp_id;
    logic [23:0]                o_rsp_color;
    logic                       o_rsp_transparent;

    palette_lookup_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_PAL(NUM_PAL), .PAL_W(PAL_W), .WR_BURST_MAX(WR_BURST_MAX)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req(i_req), .i_req_pal(i_req_pal), .i_req_idx(i_req_idx), .o_gnt(o_gnt),
        .i_wr_en(i_wr_en), .i_wr_pal(i_wr_pal), .i_wr_idx(i_wr_idx), .i_wr_color(i_wr_color),
        .o_wr_ready(o_wr_ready),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_color(o_rsp_color),
        .o_rsp_transparent(o_rsp_transparent)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [23:0] m_mem [NUM_PAL*16];
    int          m_ptr;
    int          m_bcnt;
    bit          s_vld;
    int          s_id, s_pal, s_idx;
    bit          e_vld;
    int          e_id;
    logic [23:0] e_color;
    bit          e_tr;
    int          last_gnt;
    logic [3:0]  obs_gnt;
    logic [9:0]  rdy_hist;

    task automatic model_reset();
        for (int e = 0; e < NUM_PAL*16; e++) m_mem[e] = 24'h0;
        m_ptr   = NUM_REQ - 1;
        m_bcnt  = 0;
        s_vld   = 1'b0;
        e_vld   = 1'b0;
        e_id    = 0;
        e_color = 24'h0;
        e_tr    = 1'b0;
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        int g, wp, wi, rp, ri;
        bit any, ws;
        logic [23:0] wc;
        @(negedge i_clk);
        any = (i_req != '0);
        ws  = i_wr_en && (!any || m_bcnt < WR_BURST_MAX);
        g   = -1;
        if (!ws) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                if (g < 0 && i_req[(m_ptr + i) % NUM_REQ]) g = (m_ptr + i) % NUM_REQ;
            end
        end
        obs_gnt = o_gnt;
        check_eq("gnt", o_gnt, (g >= 0) ? (32'd1 << g) : 32'd0);
        check_eq("wr_ready", o_wr_ready, ws);
        check_eq("rsp_valid", o_rsp_valid, e_vld);
        check_eq("rsp_id", o_rsp_id, e_id);
        check_eq("rsp_color", o_rsp_color, e_color);
        check_eq("rsp_transparent", o_rsp_transparent, e_tr);
        rdy_hist = {rdy_hist[8:0], o_wr_ready};
        last_gnt = g;
        wp = i_wr_pal; wi = i_wr_idx; wc = i_wr_color;
        rp = 0; ri = 0;
        if (g >= 0) begin
            rp = i_req_pal[g*PAL_W +: PAL_W];
            ri = i_req_idx[g*4 +: 4];
        end
        @(posedge i_clk);
        if (i_rst_n) begin
            if (s_vld) begin
                e_vld   = 1'b1;
                e_id    = s_id;
                e_tr    = (s_idx == 0);
                e_color = e_tr ? 24'h0 : m_mem[s_pal*16 + s_idx];
            end else begin
                e_vld = 1'b0;
            end
            if (ws) m_mem[wp*16 + wi] = wc;
            if (ws && any) m_bcnt = (m_bcnt < WR_BURST_MAX) ? m_bcnt + 1 : m_bcnt;
            else if (g >= 0 || !any) m_bcnt = 0;
            s_vld = (g >= 0);
            if (g >= 0) begin
                s_id  = g;
                s_pal = rp;
                s_idx = ri;
                m_ptr = g;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        i_req   = '0;
        i_wr_en = 1'b0;
        i_rst_n = 1'b0;
        model_reset();
        repeat (cycles) step();
        i_rst_n = 1'b1;
    endtask

    task automatic set_req(input int k, input int pal, input int idx);
        i_req[k] = 1'b1;
        i_req_pal[k*PAL_W +: PAL_W] = PAL_W'(pal);
        i_req_idx[k*4 +: 4] = 4'(idx);
    endtask

    task automatic write_entry(input int pal, input int idx, input logic [23:0] color);
        i_wr_en    = 1'b1;
        i_wr_pal   = PAL_W'(pal);
        i_wr_idx   = 4'(idx);
        i_wr_color = color;
        step();
        i_wr_en = 1'b0;
    endtask

    task automatic rand_cycle(input int wr_pct);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!i_req[k] && $urandom_range(0, 99) < 40)
                set_req(k, int'($urandom_range(0, NUM_PAL-1)), int'($urandom_range(0, 15)));
        end
        i_wr_en    = ($urandom_range(0, 99) < wr_pct);
        i_wr_pal   = PAL_W'($urandom_range(0, NUM_PAL-1));
        i_wr_idx   = 4'($urandom_range(0, 15));
        i_wr_color = 24'($urandom);
        step();
        if (last_gnt >= 0) i_req[last_gnt] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_req = '0; i_req_pal = '0; i_req_idx = '0;
        i_wr_en = 1'b0; i_wr_pal = '0; i_wr_idx = '0; i_wr_color = '0;
        rdy_hist = '0; last_gnt = -1; s_id = 0; s_pal = 0; s_idx = 0;
        do_reset(3);
        check_eq("reset_valid", o_rsp_valid, 0);
        check_eq("reset_color", o_rsp_color, 0);

        // All four requesters held: strict rotation from requester 0
        for (int k = 0; k < NUM_REQ; k++) set_req(k, k, k + 3);
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("rr_order", obs_gnt, 32'd1 << (i % 4));
        end
        i_req = '0;
        repeat (3) step();

        // Basic write then lookup
        write_entry(1, 5, 24'hb79bdc);
        set_req(2, 1, 5);
        step();
        check_eq("lookup_gnt", obs_gnt, 4'b0100);
        i_req = '0;
        step();
        check_eq("lookup_valid", o_rsp_valid, 1);
        check_eq("lookup_id", o_rsp_id, 2);
        check_eq("lookup_color", o_rsp_color, 24'hb79bdc);
        check_eq("lookup_transp", o_rsp_transparent, 0);
        step();
        check_eq("pulse_single", o_rsp_valid, 0);

        // Entry 0 is always transparent black
        write_entry(3, 0, 24'hffffff);
        set_req(1, 3, 0);
        step();
        i_req = '0;
        step();
        check_eq("transp_flag", o_rsp_transparent, 1);
        check_eq("transp_color", o_rsp_color, 24'h000000);

        // Write burst limit with requester 0 waiting
        step();
        set_req(0, 2, 9);
        i_wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_wr_pal   = 2'd2;
            i_wr_idx   = 4'($urandom_range(1, 15));
            i_wr_color = 24'($urandom);
            step();
        end
        check_eq("burst_pattern", rdy_hist, 10'b1111011110);
        i_wr_en = 1'b0;
        i_req   = '0;
        repeat (3) step();

        // Read-during-write returns the old value, a later lookup the new one
        write_entry(0, 7, 24'h10062f);
        set_req(0, 0, 7);
        step();
        i_req = '0;
        i_wr_en = 1'b1; i_wr_pal = 2'd0; i_wr_idx = 4'd7; i_wr_color = 24'h060514;
        step();
        i_wr_en = 1'b0;
        check_eq("rdw_old", o_rsp_color, 24'h10062f);
        set_req(0, 0, 7);
        step();
        i_req = '0;
        step();
        check_eq("rdw_new", o_rsp_color, 24'h060514);

        // Reset while a lookup is in flight
        step();
        set_req(3, 1, 5);
        step();
        check_eq("pre_rst_gnt", obs_gnt, 4'b1000);
        do_reset(3);
        step();
        check_eq("rst_no_pulse", o_rsp_valid, 0);
        i_req = 4'b1001;
        step();
        check_eq("post_rst_gnt", obs_gnt, 4'b0001);
        i_req = '0;
        for (int e = 0; e < NUM_PAL*16; e++) begin
            set_req(0, e / 16, e % 16);
            step();
            if (o_rsp_valid) check_eq("post_rst_zero", o_rsp_color, 24'h0);
        end
        i_req = '0;
        repeat (3) step();

        // Randomized traffic, a mid-stream reset, then write-heavy traffic
        for (int i = 0; i < 1500; i++) rand_cycle(30);
        do_reset(2);
        for (int i = 0; i < 1500; i++) rand_cycle(90);
        i_req = '0; i_wr_en = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/palette_lookup_arbiter.md
Name: palette_lookup_arbiter

Overview:
- Owns the shared sprite colour-palette storage: NUM_PAL palettes × 16 entries × 24-bit RGB, covering player, opponent, projectile and background layers.
- Arbitrates per-pixel colour lookups from NUM_REQ sprite-decoder requesters using round-robin.
- Accepts runtime palette writes from the game-control FSM, e.g. hit-flash recolouring or team swaps.
- Returns the RGB colour and a transparency flag through a 2-stage pipeline feeding the VGA compositor.

Parameters:
- NUM_REQ, 4, number of lookup requesters.
- NUM_PAL, 4, number of 16-entry palettes; must be a power of 2.
- PAL_W, 2, palette-select width, equal to log2(NUM_PAL).
- WR_BURST_MAX, 4, maximum consecutive write cycles allowed while any lookup is pending.

Ports:
- i_clk, in, 1, system clock; all state updates on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_req, in, NUM_REQ, lookup request per requester; held until granted.
- i_req_pal, in, NUM_REQ*PAL_W, palette select per requester; requester k uses slice [k*PAL_W +: PAL_W].
- i_req_idx, in, NUM_REQ*4, colour index per requester; requester k uses slice [k*4 +: 4].
- o_gnt, out, NUM_REQ, combinational one-hot grant; a lookup transfers on the edge where i_req[k] & o_gnt[k].
- i_wr_en, in, 1, palette write request.
- i_wr_pal, in, PAL_W, palette to write.
- i_wr_idx, in, 4, entry to write.
- i_wr_color, in, 24, RGB data to write.
- o_wr_ready, out, 1, combinational; a write commits on the edge where i_wr_en & o_wr_ready.
- o_rsp_valid, out, 1, response valid; a single-cycle pulse per lookup.
- o_rsp_id, out, log2(NUM_REQ), index of the requester that owns the response.
- o_rsp_color, out, 24, looked-up RGB value.
- o_rsp_transparent, out, 1, high when the looked-up index is 0.

Behaviour:
- Reset (async assert, sync release): all 64 palette entries = 24'h000000; RR pointer = NUM_REQ-1, so requester 0 has highest priority first; burst counter = 0; both pipeline stages invalid; o_rsp_valid/id/color/transparent = 0.
- Reset mid-operation: in-flight lookups are discarded, with no response pulse. Any write on the same edge as reset assertion is lost.
- Slot selection each cycle:
  - WRITE slot if i_wr_en and (no i_req bit set, or burst_cnt < WR_BURST_MAX).
  - Otherwise LOOKUP slot.
  - o_wr_ready = 1 only in a WRITE slot; o_gnt = 0 in a WRITE slot.
- Burst counter:
  - Increments on each committed write while any i_req bit is high.
  - Clears to 0 on any lookup grant, or on any cycle with no i_req bit set.
  - Saturates at WR_BURST_MAX.
- Round-robin (LOOKUP slot):
  - Grant the first set i_req bit searching from ptr+1 upward, with wrap-around modulo NUM_REQ.
  - Exactly one grant, or none if no requests.
  - ptr is set to the granted index on the grant edge; it is unchanged when nothing is granted.
- Pipeline:
  - Edge T (grant): stage 1 captures valid, id, pal, idx.
  - Edge T+1: stage 2 reads entry [pal][idx] and registers o_rsp_*.
  - o_rsp_valid is high for exactly the cycle after edge T+1. Latency = 2 edges.
  - Sustained throughput is 1 lookup per cycle.
- Transparency: if idx == 0, o_rsp_transparent = 1 and o_rsp_color = 24'h000000, regardless of stored entry 0.
- Read-during-write: if a write to the same [pal][idx] commits on edge T+1, the response carries the OLD value. The new value is visible to lookups whose stage-2 edge is later than the write edge.
- Writes to entry 0 are stored but never output, because entry 0 is transparent.
- When o_rsp_valid = 0: o_rsp_id, o_rsp_color and o_rsp_transparent hold their last values. Consumers qualify on o_rsp_valid.
- No backpressure on responses; the compositor must accept every pulse.

Test Plan:
- Reset, then write pal 1 idx 5 = 24'hb79bdc. Requester 2 looks up pal 1 idx 5 → o_gnt = 4'b0100 that cycle; o_rsp_valid 2 edges later, id = 2, color = 24'hb79bdc, transparent = 0.
- All four i_req held high for 8 cycles → grant order 0,1,2,3,0,1,2,3; 8 consecutive o_rsp_valid pulses with matching ids.
- Requester 1 looks up idx 0 of pal 3 after writing 24'hffffff there → transparent = 1, color = 24'h000000.
- i_wr_en held high for 10 cycles with i_req[0] held high → writes committed on cycles 1–4; cycle 5 grants req 0 (o_wr_ready = 0); writes resume on cycles 6–9; cycle 10 grants again.
- Lookup pal 0 idx 7 (old value 24'h10062f) whose stage-2 edge coincides with a write of 24'h060514 to the same entry → response 24'h10062f. An immediate repeat lookup → 24'h060514.
- Grant req 3, then assert i_rst_n = 0 one cycle later → no o_rsp_valid pulse. After release, the palette reads all zeros and the next simultaneous requests from 0 and 3 grant 0 first.
